// File: rtl/dm_cache_sim.sv
// dm_cache_sim: direct-mapped cache tag/valid model driven by the trace generator.
// Classifies each access as hit or miss, models a fixed miss-fill latency and
// keeps saturating access/hit/miss statistics.
//
// Optional feature macro: CACHE_FLUSH_EN (adds the flush input; valid bits
// can then be cleared from IDLE without a reset).
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high reset
//   trace_ready   mem_addr valid; request to process an access
//   mem_addr      access address (ADDR_W)
//   flush         (CACHE_FLUSH_EN only) clear all valid bits when idle
//   updated       one-cycle pulse: access complete, send next address
//   hit / miss    access result, valid with updated
//   busy          an access is in progress
//   access_count  completed accesses (saturating, CNT_W)
//   hit_count     completed hits (saturating, CNT_W)
//   miss_count    completed misses (saturating, CNT_W)
module dm_cache_sim #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned OFFSET_W = 4,
    parameter int unsigned INDEX_W  = 4,
    parameter int unsigned MISS_LAT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trace_ready,
    input  logic [ADDR_W-1:0] mem_addr,
`ifdef CACHE_FLUSH_EN
    input  logic              flush,
`endif
    output logic              updated,
    output logic              hit,
    output logic              miss,
    output logic              busy,
    output logic [CNT_W-1:0]  access_count,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int unsigned LINE_W = ADDR_W - OFFSET_W;
    localparam int unsigned TAG_W  = LINE_W - INDEX_W;
    localparam int unsigned LINES  = 2 ** INDEX_W;
    localparam int unsigned LAT_W  = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FILL   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [LINE_W-1:0]  line_q;
    logic [LAT_W-1:0]   wait_q;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem [LINES];

    logic [INDEX_W-1:0] index_c;
    logic [TAG_W-1:0]   tag_c;
    logic               lookup_hit_c;
    logic               flush_req_c;
    logic               fill_done_c;
    logic               unused_offset;

    // Block offset never affects tag/valid state.
    assign unused_offset = ^mem_addr[OFFSET_W-1:0];

    assign index_c      = line_q[INDEX_W-1:0];
    assign tag_c        = line_q[LINE_W-1:INDEX_W];
    assign lookup_hit_c = valid[index_c] && (tag_mem[index_c] == tag_c);
    assign fill_done_c  = (wait_q == '0);

`ifdef CACHE_FLUSH_EN
    assign flush_req_c = flush;
`else
    assign flush_req_c = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a flush in IDLE wins over a pending access.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (!flush_req_c && trace_ready) state_next = LOOKUP;
            LOOKUP:  state_next = lookup_hit_c ? RESP : FILL;
            FILL:    if (fill_done_c) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath, valid bits, registered outputs and statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_q       <= '0;
            wait_q       <= '0;
            valid        <= '0;
            updated      <= 1'b0;
            hit          <= 1'b0;
            miss         <= 1'b0;
            busy         <= 1'b0;
            access_count <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (flush_req_c) begin
                        valid <= '0;
                    end else if (trace_ready) begin
                        line_q <= mem_addr[ADDR_W-1:OFFSET_W];
                    end
                end
                LOOKUP: wait_q <= LAT_W'(MISS_LAT - 1);
                FILL: begin
                    if (fill_done_c) begin
                        valid[index_c] <= 1'b1;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                RESP: begin
                    if (access_count != '1) access_count <= access_count + 1'b1;
                    if (hit && (hit_count != '1)) hit_count <= hit_count + 1'b1;
                    if (miss && (miss_count != '1)) miss_count <= miss_count + 1'b1;
                end
                default: ;
            endcase

            // Outputs track the state being entered so they line up with RESP.
            updated <= (state_next == RESP);
            hit     <= (state == LOOKUP) && (state_next == RESP);
            miss    <= (state == FILL) && (state_next == RESP);
            busy    <= (state_next != IDLE);
        end
    end

    // Tag storage needs no reset; valid bits qualify it.
    always_ff @(posedge clk) begin
        if (!reset && (state == FILL) && fill_done_c) begin
            tag_mem[index_c] <= tag_c;
        end
    end

endmodule

// File: tb/tb_dm_cache_sim.sv
// tb_dm_cache_sim: directed and randomized checks of dm_cache_sim against a
// line-array reference model. Two instances share the stimulus: u_dut with
// default counters and u_sat with 4-bit counters for saturation.
module tb_dm_cache_sim;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned OFFSET_W = 4;
    localparam int unsigned INDEX_W  = 4;
    localparam int unsigned MISS_LAT = 4;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned SAT_W    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              trace_ready;
    logic [ADDR_W-1:0] mem_addr;
`ifdef CACHE_FLUSH_EN
    logic              flush;
`endif

    logic              updated, hit, miss, busy;
    logic [CNT_W-1:0]  access_count, hit_count, miss_count;
    logic              s_updated, s_hit, s_miss, s_busy;
    logic [SAT_W-1:0]  s_access_count, s_hit_count, s_miss_count;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: per-line valid/tag plus unbounded statistics.
    bit          m_valid [16];
    logic [23:0] m_tag   [16];
    int          m_acc, m_hit, m_miss;

    always #5 clk = ~clk;

    dm_cache_sim #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W),
                   .MISS_LAT(MISS_LAT), .CNT_W(CNT_W)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .trace_ready  (trace_ready),
        .mem_addr     (mem_addr),
`ifdef CACHE_FLUSH_EN
        .flush        (flush),
`endif
        .updated      (updated),
        .hit          (hit),
        .miss         (miss),
        .busy         (busy),
        .access_count (access_count),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    dm_cache_sim #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W),
                   .MISS_LAT(MISS_LAT), .CNT_W(SAT_W)) u_sat (
        .clk          (clk),
        .reset        (reset),
        .trace_ready  (trace_ready),
        .mem_addr     (mem_addr),
`ifdef CACHE_FLUSH_EN
        .flush        (flush),
`endif
        .updated      (s_updated),
        .hit          (s_hit),
        .miss         (s_miss),
        .busy         (s_busy),
        .access_count (s_access_count),
        .hit_count    (s_hit_count),
        .miss_count   (s_miss_count)
    );

    function automatic int sat(input int x, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", name, obs, exp);
        end
    endtask

    task automatic check_counts(input string name);
        check({name, "_acc"},    32'(access_count),   32'(sat(m_acc, CNT_W)));
        check({name, "_hit"},    32'(hit_count),      32'(sat(m_hit, CNT_W)));
        check({name, "_miss"},   32'(miss_count),     32'(sat(m_miss, CNT_W)));
        check({name, "_s_acc"},  32'(s_access_count), 32'(sat(m_acc, SAT_W)));
        check({name, "_s_hit"},  32'(s_hit_count),    32'(sat(m_hit, SAT_W)));
        check({name, "_s_miss"}, 32'(s_miss_count),   32'(sat(m_miss, SAT_W)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        trace_ready = 1'b0;
`ifdef CACHE_FLUSH_EN
        flush = 1'b0;
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_acc = 0; m_hit = 0; m_miss = 0;
        check("rst_updated", 32'(updated), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_hitmiss", 32'({hit, miss}), 0);
        check_counts("rst");
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Called at cycle 1 after the edge that accepted addr; waits for the response.
    task automatic wait_resp(input logic [31:0] a);
        int        lat;
        bit        exp_hit;
        int        idx;
        logic [23:0] tg;
        idx = int'(a[7:4]);
        tg  = a[31:8];
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        lat = 1;
        while (updated !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("updated", 32'(updated), 1);
        check("latency", 32'(lat), exp_hit ? 32'd2 : 32'(2 + MISS_LAT));
        check("hit", 32'(hit), 32'(exp_hit));
        check("miss", 32'(miss), 32'(!exp_hit));
        check("sat_hit", 32'(s_hit), 32'(exp_hit));
        m_acc++;
        if (exp_hit) begin
            m_hit++;
        end else begin
            m_miss++;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
        @(posedge clk);
        #1;
        check("pulse_width", 32'(updated), 0);
        check_counts("counts");
    endtask

    task automatic do_access(input logic [31:0] a);
        @(negedge clk);
        mem_addr    = a;
        trace_ready = 1'b1;
        @(posedge clk);
        #1;
        trace_ready = 1'b0;
        wait_resp(a);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        reset = 1'b1;
        trace_ready = 1'b0;
        mem_addr = '0;
`ifdef CACHE_FLUSH_EN
        flush = 1'b0;
`endif
        do_reset();

        // Sequential trace within one block, then a different index.
        for (int i = 0; i < 8; i++) do_access(32'h0443_2090 + 32'(i));
        do_access(32'h0443_2090);
        do_access(32'h0443_2FC5);
        check("trace_acc", 32'(access_count), 10);
        check("trace_hit", 32'(hit_count), 8);
        check("trace_miss", 32'(miss_count), 2);

        // Conflicting tags on index 9.
        do_reset();
        do_access(32'h0000_0090);
        do_access(32'h0000_1090);
        do_access(32'h0000_0090);
        check("conflict_miss", 32'(miss_count), 3);
        check("conflict_hit", 32'(hit_count), 0);

        // Reset during FILL discards the fill.
        do_reset();
        @(negedge clk);
        mem_addr = 32'h0000_0090;
        trace_ready = 1'b1;
        @(posedge clk);
        #1;
        trace_ready = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            @(posedge clk);
            #1;
            check("fill_no_updated", 32'(updated), 0);
        end
        do_reset();
        do_access(32'h0000_0090);
        check("refill_miss", 32'(miss), 0);
        check("refill_miss_count", 32'(miss_count), 1);

        // Saturation of the narrow counters.
        do_reset();
        for (int i = 0; i < 21; i++) do_access(32'h0000_0090 + 32'(i % 16));
        check("sat_hit_count", 32'(s_hit_count), 15);
        check("sat_acc_count", 32'(s_access_count), 15);
        check("sat_miss_count", 32'(s_miss_count), 1);
        check("wide_hit_count", 32'(hit_count), 20);

        // Randomized accesses over a few tags to mix hits and misses.
        do_reset();
        for (int i = 0; i < 150; i++) begin
            a = {24'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            do_access(a);
        end

`ifdef CACHE_FLUSH_EN
        // Flush clears valid bits but not statistics.
        do_reset();
        do_access(32'h0000_0090);
        do_access(32'h0000_0090);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        check("flush_busy", 32'(busy), 0);
        check("flush_acc", 32'(access_count), 2);
        do_access(32'h0000_0090);
        check("flush_miss_count", 32'(miss_count), 2);
        check("flush_hit_count", 32'(hit_count), 1);

        // Flush and trace_ready together: flush first, access next cycle.
        @(negedge clk);
        mem_addr = 32'h0000_0090;
        trace_ready = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        check("flush_prio_busy0", 32'(busy), 0);
        @(posedge clk);
        #1;
        trace_ready = 1'b0;
        check("flush_prio_busy1", 32'(busy), 1);
        wait_resp(32'h0000_0090);
        check("flush_prio_miss", 32'(miss_count), 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
